// File: rtl/cpu_mem_host.sv
// Memory and control responder for the pipelined CPU: on-chip IMEM/DMEM serving the fetch and
// data ports, host preload/launch/halt sequencing, run-cycle counting and DMEM readback.
module cpu_mem_host #(
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = 16,
    parameter logic [4:0] HALT_OPCODE = 5'b00001
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    output logic              cpu_reset,
    output logic              cpu_enable,
    output logic              cpu_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              go,
    input  logic              clear,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              halted,
    output logic [15:0]       cycles
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] imem_r [DEPTH];
    logic [DATA_W-1:0] dmem_r [DEPTH];
    logic [DATA_W-1:0] i_datain_r;
    logic [DATA_W-1:0] d_datain_r;
    logic [DATA_W-1:0] dump_data_r;
    logic              cpu_reset_r;
    logic              cpu_enable_r;
    logic              cpu_start_r;
    logic              ld_ready_r;
    logic              halted_r;
    logic [15:0]       cycles_r;
    logic              ld_accept_s;
    logic              cpu_store_s;

    function automatic logic is_halt(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: 5] == HALT_OPCODE;
    endfunction

    assign ld_accept_s = reset && (state_r == ST_IDLE) && ld_valid;
    assign cpu_store_s = reset && (state_r == ST_RUN) && d_we;

    // Memory array writes: host preload in IDLE, CPU stores in RUN; never cleared by reset
    always_ff @(posedge clock) begin
        if (ld_accept_s && !ld_sel) begin
            imem_r[ld_addr] <= ld_data;
        end
        if (ld_accept_s && ld_sel) begin
            dmem_r[ld_addr] <= ld_data;
        end else if (cpu_store_s) begin
            dmem_r[d_addr] <= d_dataout;
        end
    end

    // Sequencing FSM with registered CPU control, read ports and cycle counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            i_datain_r   <= {DATA_W{1'b0}};
            d_datain_r   <= {DATA_W{1'b0}};
            dump_data_r  <= {DATA_W{1'b0}};
            cpu_reset_r  <= 1'b0;
            cpu_enable_r <= 1'b0;
            cpu_start_r  <= 1'b0;
            ld_ready_r   <= 1'b1;
            halted_r     <= 1'b0;
            cycles_r     <= 16'd0;
        end else begin
            dump_data_r <= dmem_r[dump_addr];
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        state_r      <= ST_LAUNCH;
                        cpu_reset_r  <= 1'b1;
                        cpu_enable_r <= 1'b1;
                        cpu_start_r  <= 1'b1;
                        ld_ready_r   <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    // The launch cycle already serves a fetch, so a HALT word left over
                    // from a previous run cannot stop the new run on its first cycle.
                    i_datain_r  <= imem_r[i_addr];
                    d_datain_r  <= dmem_r[d_addr];
                    cpu_start_r <= 1'b0;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    i_datain_r <= imem_r[i_addr];
                    d_datain_r <= dmem_r[d_addr];
                    if (cycles_r != 16'hFFFF) begin
                        cycles_r <= cycles_r + 16'd1;
                    end
                    if (is_halt(i_datain_r)) begin
                        state_r      <= ST_HALTED;
                        cpu_enable_r <= 1'b0;
                        halted_r     <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (clear) begin
                        state_r     <= ST_IDLE;
                        cycles_r    <= 16'd0;
                        halted_r    <= 1'b0;
                        cpu_reset_r <= 1'b0;
                        ld_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cpu_reset_r  <= 1'b0;
                    cpu_enable_r <= 1'b0;
                    cpu_start_r  <= 1'b0;
                    ld_ready_r   <= 1'b1;
                    halted_r     <= 1'b0;
                    cycles_r     <= 16'd0;
                end
            endcase
        end
    end

    assign i_datain   = i_datain_r;
    assign d_datain   = d_datain_r;
    assign dump_data  = dump_data_r;
    assign cpu_reset  = cpu_reset_r;
    assign cpu_enable = cpu_enable_r;
    assign cpu_start  = cpu_start_r;
    assign ld_ready   = ld_ready_r;
    assign halted     = halted_r;
    assign cycles     = cycles_r;

endmodule
